// File: rtl/pe_xbar_pkg.sv
// Shared constants and width helpers for the context-switched PE crossbar.
package pe_xbar_pkg;

  localparam bit FILL_BIT = 1'b1;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int sel_width(input int n_in);
    return clog2_min1(n_in);
  endfunction

  function automatic int ctx_width(input int n_ctx);
    return clog2_min1(n_ctx);
  endfunction

  // Channel map of the default 9x6 PE
  localparam int IN_N  = 0;
  localparam int IN_S  = 1;
  localparam int IN_W  = 2;
  localparam int IN_E  = 3;
  localparam int IN_R0 = 4;
  localparam int IN_R1 = 5;
  localparam int IN_R2 = 6;
  localparam int IN_R3 = 7;
  localparam int IN_FU = 8;

  localparam int OUT_E   = 0;
  localparam int OUT_W   = 1;
  localparam int OUT_S   = 2;
  localparam int OUT_N   = 3;
  localparam int OUT_OPB = 4;
  localparam int OUT_OPA = 5;

endpackage

// File: rtl/pe_xbar_mux.sv
// One N_IN:1 output mux; unused select codes give all-ones and raise oor_o.
module pe_xbar_mux
  import pe_xbar_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N_IN   = 9,
  parameter int SEL_W  = 4
) (
  input  logic [N_IN*DATA_W-1:0] din_i,
  input  logic [SEL_W-1:0]       sel_i,
  output logic [DATA_W-1:0]      dout_o,
  output logic                   oor_o
);

  always_comb begin
    dout_o = {DATA_W{FILL_BIT}};
    oor_o  = 1'b1;
    for (int i = 0; i < N_IN; i++) begin
      if (sel_i == SEL_W'(i)) begin
        dout_o = din_i[i*DATA_W +: DATA_W];
        oor_o  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/pe_crossbar_ctx.sv
// Registered N_IN x N_OUT crossbar with a multi-context switch store and a
// single valid/ready output stage.
module pe_crossbar_ctx
  import pe_xbar_pkg::*;
#(
  parameter int  DATA_W = 32,
  parameter int  N_IN   = 9,
  parameter int  N_OUT  = 6,
  parameter int  N_CTX  = 4,
  localparam int SEL_W  = sel_width(N_IN),
  localparam int CTX_W  = ctx_width(N_CTX)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_IN*DATA_W-1:0]  din,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N_OUT*DATA_W-1:0] dout,
  input  logic                    cfg_we,
  input  logic [CTX_W-1:0]        cfg_ctx,
  input  logic [N_OUT*SEL_W-1:0]  cfg_data,
  input  logic                    ctx_load,
  input  logic [CTX_W-1:0]        ctx_sel,
  output logic [CTX_W-1:0]        active_ctx,
  output logic                    sel_err,
  input  logic                    err_clr
);

  logic [N_OUT*SEL_W-1:0]  ctx_q [N_CTX];
  logic [CTX_W-1:0]        active_ctx_q, active_ctx_d;
  logic [N_OUT*DATA_W-1:0] dout_q, dout_d;
  logic                    out_valid_q, out_valid_d;
  logic                    sel_err_q, sel_err_d;
  logic [N_OUT*SEL_W-1:0]  cur_word;
  logic [N_OUT*DATA_W-1:0] mux_out;
  logic [N_OUT-1:0]        oor;
  logic                    capture;

  // The active word is read before any same-edge write or context switch lands
  assign cur_word = ctx_q[active_ctx_q];

  for (genvar k = 0; k < N_OUT; k++) begin : g_mux
    pe_xbar_mux #(
      .DATA_W(DATA_W),
      .N_IN  (N_IN),
      .SEL_W (SEL_W)
    ) u_mux (
      .din_i (din),
      .sel_i (cur_word[k*SEL_W +: SEL_W]),
      .dout_o(mux_out[k*DATA_W +: DATA_W]),
      .oor_o (oor[k])
    );
  end

  assign in_ready = !out_valid_q || out_ready;
  assign capture  = in_valid && in_ready;

  always_comb begin
    dout_d       = dout_q;
    out_valid_d  = out_valid_q;
    sel_err_d    = sel_err_q;
    active_ctx_d = active_ctx_q;
    if (capture) begin
      dout_d      = mux_out;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    // A bad capture wins over a simultaneous clear
    if (err_clr) sel_err_d = 1'b0;
    if (capture && |oor) sel_err_d = 1'b1;
    if (ctx_load && int'(ctx_sel) < N_CTX) active_ctx_d = ctx_sel;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CTX; c++) ctx_q[c] <= '0;
      active_ctx_q <= '0;
      dout_q       <= '0;
      out_valid_q  <= 1'b0;
      sel_err_q    <= 1'b0;
    end else begin
      if (cfg_we && int'(cfg_ctx) < N_CTX) ctx_q[cfg_ctx] <= cfg_data;
      active_ctx_q <= active_ctx_d;
      dout_q       <= dout_d;
      out_valid_q  <= out_valid_d;
      sel_err_q    <= sel_err_d;
    end
  end

  assign dout       = dout_q;
  assign out_valid  = out_valid_q;
  assign active_ctx = active_ctx_q;
  assign sel_err    = sel_err_q;

endmodule

// File: doc/pe_crossbar_ctx.md
Name: pe_crossbar_ctx

Overview:
- Parametrised, registered successor to the PE 9x6 operand/route crossbar.
- Routes N_IN data inputs to N_OUT outputs through per-output selects taken from a multi-context configuration store.
- Outputs sit behind a single valid/ready pipeline register, so PE-to-PE links are timing-isolated.
- Sits between the PE neighbour/register-file inputs and the FU operand ports and N/S/W/E outputs; configuration contexts are switched at run time without reloading.

Parameters:
DATA_W, 32, data path width per channel
N_IN, 9, number of input channels (N,S,W,E,R0..R3,fu_res in the default PE)
N_OUT, 6, number of output channels (E,W,S,N,op_B,op_A as channels 0..5)
N_CTX, 4, number of stored switch contexts
SEL_W, $clog2(N_IN) (localparam), select width per output
CTX_W, max(1,$clog2(N_CTX)) (localparam), context index width

Ports:
clk  input  1  clock
rst_n  input  1  reset; synchronous, active-low
in_valid  input  1  din beat valid
in_ready  output  1  stage can accept a beat
din  input  N_IN*DATA_W  input channel i at [i*DATA_W +: DATA_W]
out_valid  output  1  dout holds a valid beat
out_ready  input  1  downstream accepts dout
dout  output  N_OUT*DATA_W  output channel k at [k*DATA_W +: DATA_W]
cfg_we  input  1  write one context word
cfg_ctx  input  CTX_W  context index written
cfg_data  input  N_OUT*SEL_W  switch word; select for output k at [k*SEL_W +: SEL_W]
ctx_load  input  1  load active context from ctx_sel
ctx_sel  input  CTX_W  new active context
active_ctx  output  CTX_W  currently active context
sel_err  output  1  sticky: a captured beat used an out-of-range select
err_clr  input  1  clears sel_err

Behaviour:
- Reset (rst_n=0 at a clk edge): every context word = 0, active_ctx = 0, dout = 0, out_valid = 0, sel_err = 0. Reset mid-transfer discards the held beat; no partial state survives.
- in_ready = !out_valid || out_ready (combinational; no in_valid->in_ready path).
- Capture: in_valid && in_ready at an edge -> dout[k] <= sel_k < N_IN ? din[sel_k] : {DATA_W{1'b1}}, with sel_k taken from context word active_ctx. out_valid <= 1.
- No capture but out_ready && out_valid -> out_valid <= 0; dout holds its last value.
- Stall (out_valid && !out_ready): dout and out_valid hold; in_ready = 0.
- Latency: exactly 1 cycle din->dout; full throughput with out_ready held high.
- cfg_we: writes cfg_data into word cfg_ctx at the edge. A cfg_ctx >= N_CTX write is ignored. A capture in the same cycle uses the pre-write value (write visible next cycle).
- ctx_load: active_ctx <= ctx_sel at the edge, unless ctx_sel >= N_CTX (ignored, active_ctx unchanged). A capture in the same cycle uses the old context.
- cfg_we and ctx_load in the same cycle are independent; both take effect.
- sel_err is set at a capture edge where any sel_k >= N_IN. err_clr clears it. Set beats clear when both occur in one cycle.
- Unused select codes (N_IN..2^SEL_W-1) always produce the all-ones fill and never alias an input.
- Several outputs may select the same input; an output may select its own-direction input (loopback).

Decomposition:
- Package pe_xbar_pkg holds:
  - the fill constant for out-of-range selects (all-ones, width-generic);
  - the clog2-derived width helpers (SEL_W, CTX_W);
  - channel-index constants for the default 9x6 PE (IN_N..IN_FU, OUT_E..OUT_OPA).
- Sub-module pe_xbar_mux: one combinational N_IN:1 mux with fill and an out-of-range flag, instantiated N_OUT times by generate. The config store, context register, pipeline register and error flag stay in the top.

Test Plan:
1. Reset check: after reset, dout=0, out_valid=0, active_ctx=0, sel_err=0. Then din[i]=32'h1000_0000+i with ctx0 all-zero and one beat -> every dout[k]=32'h1000_0000 after 1 cycle.
2. Routing and latency: write ctx1 with sel = {8,7,3,2,1,0} (k=5..0), ctx_load=1/ctx_sel=1, then stream 4 beats with out_ready=1 -> each dout matches its selected din exactly one cycle later; in_ready stays 1 throughout.
3. Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and dout frozen on the first beat. Release -> next beat captured, no beat lost or duplicated.
4. Out-of-range select: ctx2 select for k=0 set to 4'd12 -> dout[0]=32'hFFFF_FFFF and sel_err=1. err_clr alone -> 0. err_clr together with another bad capture -> sel_err stays 1.
5. Same-cycle hazards: cfg_we to active ctx0 together with a capture -> beat routed by the old word, the next beat by the new word. ctx_load with ctx_sel=3 and N_CTX=3 -> active_ctx unchanged; cfg_we with cfg_ctx=3 -> no word changes.
6. Reset mid-stall: out_valid=1, out_ready=0, assert rst_n=0 for one edge -> out_valid=0, dout=0, all contexts zero, active_ctx=0.
